fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the control decoder. Holds the PC and fetches one 32-bit instruction at a time over a req/ack instruction-memory port. Presents the instruction and its decoder fields (opcode, funct3, funct7[5]) with a valid/ready handshake. On each consumed instruction, advances the PC to PC+4 or to the branch/jump target, selected by the decoder's PCSrc.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
WAIT_LIMIT, 255, max cycles to wait for imem_ack before timeout; 0 disables the watchdog.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request, held high until ack
imem_addr  output  32  fetch address (= pc), stable while imem_req high
imem_ack  input  1  instruction data valid this cycle
imem_rdata  input  32  instruction word
instr_valid  output  1  instr/fields valid for execute
instr_ready  input  1  execute consumes instruction this cycle
instr  output  32  registered instruction
opcode  output  7  instr[6:0]
funct3  output  3  instr[14:12]
funct75  output  1  instr[30]
pc  output  32  address of current instruction
pc_plus4  output  32  pc + 4, modulo 2^32
pc_src  input  1  decoder PCSrc: 1 = take pc_target
pc_target  input  32  branch/jump target (pc + imm, computed downstream)
halted  output  1  sticky fault indicator
fault_code  output  2  00 none, 01 misaligned target, 10 fetch timeout
instret  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset values: pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, halted=0, fault_code=00, instret=0, wait counter=0, state=IDLE.
- States: IDLE, FETCH, ISSUE, HALT. All outputs are decoded from registered state and registers. No combinational path from imem_ack to imem_req.
- IDLE: imem_req=0. Goes to FETCH next cycle unconditionally.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, wait counter cleared, go to ISSUE.
  - An ack in the first FETCH cycle is legal, giving a minimum fetch latency of 1 cycle (req→instr_valid on the next edge).
  - Otherwise the wait counter increments. If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT with no ack: fault_code<=10, go to HALT.
- ISSUE: instr_valid=1; instr/fields/pc stable until consumed.
  - instr_valid && instr_ready: next_pc = pc_src ? pc_target : pc_plus4.
  - If next_pc[1:0]!=00: fault_code<=01, go to HALT, pc unchanged, instruction not counted.
  - Otherwise pc<=next_pc, go to FETCH, instret increments.
  - pc_src/pc_target are sampled only in the consuming cycle; ignored otherwise.
- HALT: imem_req=0, instr_valid=0, halted=1. Left only by reset.
- imem_ack is ignored in IDLE, ISSUE and HALT. A late ack after reset or fault has no effect.
- Reset mid-fetch abandons the outstanding request; the memory side tolerates the dropped req.
- PC arithmetic is 32-bit, wrapping: pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000, which is legal.
- The wait counter is $clog2(WAIT_LIMIT+1) bits wide, minimum 1.

Optional Feature:
INSTR_COUNT_EN: when defined, instret is a 32-bit counter of consumed, non-faulting instructions. It wraps at 2^32 and is cleared by reset. When undefined, no counter logic is built and instret is tied to 32'h0. All other behaviour is identical.

Test Plan:
- Reset release, imem_ack in the first FETCH cycle with rdata=32'h00500093 → imem_addr=0; one cycle later instr_valid=1, opcode=7'b0010011, funct3=000, pc_plus4=4.
- Four sequential consumes with pc_src=0 → imem_addr sequence 0,4,8,12; instret=4 when INSTR_COUNT_EN is defined, else 0.
- pc=8, consume with pc_src=1, pc_target=32'h40 → next imem_addr=32'h40. Same with pc_src=0 → 32'hC. pc_target changing while instr_ready=0 has no effect.
- Consume with pc_src=1, pc_target=32'h42 → halted=1, fault_code=01, pc stays 8, imem_req stays 0 until reset.
- WAIT_LIMIT=4, ack never arrives → halted=1, fault_code=10 four cycles after entering FETCH. A subsequent ack is ignored. Reset restores pc=RESET_PC.
- Assert reset during FETCH, then ack one cycle later → ack ignored; fetch restarts from RESET_PC via IDLE.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the control decoder.
// Holds the PC, fetches one word at a time over a req/ack port, and
// presents the instruction plus decoder fields with a valid/ready handshake.
// Optional feature macro: INSTR_COUNT_EN (retired-instruction counter).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct75,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        halted,
  output logic [1:0]  fault_code,
  output logic [31:0] instret
);

  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc_nxt;
  logic [31:0]     instr_nxt;
  logic [31:0]     next_pc;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
  logic [1:0]      fault_nxt;
  logic            wait_expired;

  assign pc_plus4    = pc + 32'd4;
  assign next_pc     = pc_src ? pc_target : pc_plus4;
  assign imem_addr   = pc;
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == ISSUE);
  assign halted      = (state == HALT);
  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct75     = instr[30];

  // The current FETCH cycle is the last one allowed before the watchdog fires.
  assign wait_expired = (WAIT_LIMIT != 0) && ((32'(wait_cnt) + 32'd1) == 32'(WAIT_LIMIT));

  // State, PC, instruction, wait counter and fault code registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instr      <= 32'h0000_0013;
      wait_cnt   <= '0;
      fault_code <= FAULT_NONE;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      instr      <= instr_nxt;
      wait_cnt   <= wait_cnt_nxt;
      fault_code <= fault_nxt;
    end
  end

  // Next-state and datapath update; acks outside FETCH are deliberately ignored.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = instr;
    wait_cnt_nxt = wait_cnt;
    fault_nxt    = fault_code;
    case (state)
      IDLE: begin
        wait_cnt_nxt = '0;
        state_nxt    = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_nxt    = imem_rdata;
          wait_cnt_nxt = '0;
          state_nxt    = ISSUE;
        end else if (wait_expired) begin
          fault_nxt = FAULT_TIMEOUT;
          state_nxt = HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          if (next_pc[1:0] != 2'b00) begin
            fault_nxt = FAULT_MISALIGN;
            state_nxt = HALT;
          end else begin
            pc_nxt    = next_pc;
            state_nxt = FETCH;
          end
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic retire;

  assign retire = (state == ISSUE) && instr_ready && (next_pc[1:0] == 2'b00);

  // Count every consumed instruction whose successor PC is legal; wraps at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret <= 32'd0;
    end else if (retire) begin
      instret <= instret + 32'd1;
    end
  end
`else
  assign instret = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed bench for fetch_unit.
// Each record gives the inputs applied before a rising edge and the
// state expected just after it; sequences cover reset, branches, a
// misaligned target, PC wrap, the fetch watchdog and reset mid-fetch.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct75;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        halted;
  logic [1:0]  fault_code;
  logic [31:0] instret;

`ifdef INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        src;
    logic [31:0] target;
    logic        e_req;
    logic        e_valid;
    logic        e_halt;
    logic [1:0]  e_fault;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   nChecks;
  int   nPass;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .WAIT_LIMIT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct75     (funct75),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .halted      (halted),
    .fault_code  (fault_code),
    .instret     (instret)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic addVec(input logic rst, input logic ack, input logic [31:0] rdata,
                        input logic ready, input logic src, input logic [31:0] target,
                        input logic e_req, input logic e_valid, input logic e_halt,
                        input logic [1:0] e_fault, input logic [31:0] e_pc,
                        input logic [31:0] e_instr, input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.ready = ready;
    v.src = src; v.target = target;
    v.e_req = e_req; v.e_valid = e_valid; v.e_halt = e_halt; v.e_fault = e_fault;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL vec%0d %s: got %h, expected %h", idx, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset       = v.rst;
    imem_ack    = v.ack;
    imem_rdata  = v.rdata;
    instr_ready = v.ready;
    pc_src      = v.src;
    pc_target   = v.target;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ei;
    logic [31:0] ep4;
    nChecks     = 0;
    nPass       = 0;
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    pc_target   = 32'h0;

    //      rst ack rdata          rdy src target          req val hlt flt    pc             instr          cnt
    // Reset state and first fetch with ack in the first FETCH cycle.
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 0);
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 0);
    addVec(0, 1, 32'h0050_0093,  0, 0, 32'h0,          0, 1, 0, 2'b00, 32'h0000_0000, 32'h0050_0093, 0);
    // Sequential consumes, one with a stalled ack.
    addVec(0, 0, 32'h0,          1, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0004, 32'h0050_0093, 1);
    addVec(0, 1, 32'h4020_8033,  0, 0, 32'h0,          0, 1, 0, 2'b00, 32'h0000_0004, 32'h4020_8033, 1);
    addVec(0, 0, 32'h0,          1, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0008, 32'h4020_8033, 2);
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0008, 32'h4020_8033, 2);
    addVec(0, 1, 32'h0000_2003,  0, 0, 32'h0,          0, 1, 0, 2'b00, 32'h0000_0008, 32'h0000_2003, 2);
    // pc_src/pc_target wiggling while not ready has no effect.
    addVec(0, 1, 32'hFFFF_FFFF,  0, 1, 32'h0000_0040,  0, 1, 0, 2'b00, 32'h0000_0008, 32'h0000_2003, 2);
    addVec(0, 0, 32'h0,          0, 1, 32'h0000_0042,  0, 1, 0, 2'b00, 32'h0000_0008, 32'h0000_2003, 2);
    addVec(0, 0, 32'h0,          1, 0, 32'h0000_0040,  1, 0, 0, 2'b00, 32'h0000_000C, 32'h0000_2003, 3);
    addVec(0, 1, 32'h00C0_006F,  0, 0, 32'h0,          0, 1, 0, 2'b00, 32'h0000_000C, 32'h00C0_006F, 3);
    addVec(0, 0, 32'h0,          1, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0010, 32'h00C0_006F, 4);
    // Taken branch to 0x40.
    addVec(0, 1, 32'h0000_0063,  0, 0, 32'h0,          0, 1, 0, 2'b00, 32'h0000_0010, 32'h0000_0063, 4);
    addVec(0, 0, 32'h0,          1, 1, 32'h0000_0040,  1, 0, 0, 2'b00, 32'h0000_0040, 32'h0000_0063, 5);
    // Misaligned target halts with fault 01, pc held, not counted.
    addVec(0, 1, 32'h0000_1063,  0, 0, 32'h0,          0, 1, 0, 2'b00, 32'h0000_0040, 32'h0000_1063, 5);
    addVec(0, 0, 32'h0,          1, 1, 32'h0000_0042,  0, 0, 1, 2'b01, 32'h0000_0040, 32'h0000_1063, 5);
    addVec(0, 1, 32'h1234_5678,  1, 0, 32'h0,          0, 0, 1, 2'b01, 32'h0000_0040, 32'h0000_1063, 5);
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          0, 0, 1, 2'b01, 32'h0000_0040, 32'h0000_1063, 5);
    // Reset, then wrap through 0xFFFFFFFC.
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 0);
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 0);
    addVec(0, 1, 32'h0010_0113,  0, 0, 32'h0,          0, 1, 0, 2'b00, 32'h0000_0000, 32'h0010_0113, 0);
    addVec(0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  1, 0, 0, 2'b00, 32'hFFFF_FFFC, 32'h0010_0113, 1);
    addVec(0, 1, 32'h0000_0013,  0, 0, 32'h0,          0, 1, 0, 2'b00, 32'hFFFF_FFFC, 32'h0000_0013, 1);
    addVec(0, 0, 32'h0,          1, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 2);
    // Watchdog: no ack for four FETCH cycles.
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 2);
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 2);
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 2);
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          0, 0, 1, 2'b10, 32'h0000_0000, 32'h0000_0013, 2);
    addVec(0, 1, 32'hCAFE_F00D,  1, 0, 32'h0,          0, 0, 1, 2'b10, 32'h0000_0000, 32'h0000_0013, 2);
    // Reset clears the fault; then reset mid-fetch and a late ack.
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 0);
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 0);
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 0);
    addVec(0, 1, 32'hDEAD_BEEF,  0, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 0);
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0013, 0);
    addVec(0, 1, 32'h0010_0093,  0, 0, 32'h0,          0, 1, 0, 2'b00, 32'h0000_0000, 32'h0010_0093, 0);

    @(posedge clk);
    #1;

    // Apply each record and compare every observable output.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      ei  = vecs[i].e_instr;
      ep4 = vecs[i].e_pc + 32'd4;
      checkOutput("imem_req",    i, {31'b0, imem_req},    {31'b0, vecs[i].e_req});
      checkOutput("imem_addr",   i, imem_addr,            vecs[i].e_pc);
      checkOutput("instr_valid", i, {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      checkOutput("halted",      i, {31'b0, halted},      {31'b0, vecs[i].e_halt});
      checkOutput("fault_code",  i, {30'b0, fault_code},  {30'b0, vecs[i].e_fault});
      checkOutput("pc",          i, pc,                   vecs[i].e_pc);
      checkOutput("pc_plus4",    i, pc_plus4,             ep4);
      checkOutput("instr",       i, instr,                ei);
      checkOutput("opcode",      i, {25'b0, opcode},      {25'b0, ei[6:0]});
      checkOutput("funct3",      i, {29'b0, funct3},      {29'b0, ei[14:12]});
      checkOutput("funct75",     i, {31'b0, funct75},     {31'b0, ei[30]});
      checkOutput("instret",     i, instret,              CNT_EN ? vecs[i].e_cnt : 32'h0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
